dmem_refill_arbiter: RTL and testbench

- Shares the single 128-bit block-read port of the data memory between two refill requesters: port 0 (data cache) and port 1 (instruction/prefetch path).
- Round-robin arbitration; issues one aligned 16-byte block read per request and captures the registered memory output.
- Returns the block to the winning requester with a one-cycle response pulse.
- Sits between the cache controllers and the data memory.

---
 rtl/dmem_refill_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_refill_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_refill_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_refill_arbiter
//   Shares the 128-bit block-read port of the data memory between two refill
//   requesters (port 0: data cache, port 1: instruction/prefetch path).
//   Round-robin arbitration, one aligned 16-byte block read per request,
//   one-cycle response pulse back to the winning requester.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
//   reqN_ready are both high. reqN_ready is combinational and only ever high
//   in IDLE, for the single winning port. The requester holds reqN_valid and
//   reqN_addr until it sees ready. respN_valid is a one-cycle pulse; respN_data
//   and respN_err are valid with it and hold until that port's next response.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   reqN_valid     requester N has a pending block read
//   reqN_addr      requester N byte address, bits [3:0] ignored
//   reqN_ready     requester N accepted this cycle (combinational)
//   respN_valid    one-cycle response pulse for requester N
//   respN_data     block data, byte 0 in bits [7:0]
//   respN_err      block was out of range (qualified by respN_valid)
//   mem_read       block read strobe to the data memory
//   mem_address    block base address, bits [3:0] always 0
//   mem_block_in   registered block output of the data memory
//   busy           FSM is not in IDLE
//   dbg_state      current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// ---------------------------------------------------------------------------
module dmem_refill_arbiter #(
  parameter int ADDR_LIMIT  = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [31:0]  req0_addr,
  output logic         req0_ready,
  output logic         resp0_valid,
  output logic [127:0] resp0_data,
  output logic         resp0_err,
  input  logic         req1_valid,
  input  logic [31:0]  req1_addr,
  output logic         req1_ready,
  output logic         resp1_valid,
  output logic [127:0] resp1_data,
  output logic         resp1_err,
  output logic         mem_read,
  output logic [31:0]  mem_address,
  input  logic [127:0] mem_block_in,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_q;
  logic           last_grant_q;
  logic           port_q;
  logic           oor_q;
  logic [31:0]    addr_q;
  logic [3:0]     cnt_q;
  logic           mem_read_q;
  logic           resp0_valid_q, resp1_valid_q;
  logic [127:0]   resp0_data_q, resp1_data_q;
  logic           resp0_err_q, resp1_err_q;

  logic           grant0, grant1;
  logic [31:0]    acc_addr;
  logic [31:0]    acc_base;
  logic [32:0]    acc_end;
  logic           acc_oor;
  logic [7:0]     unused_addr_bits;

  assign unused_addr_bits = {req0_addr[3:0], req1_addr[3:0]};

  // A lone requester wins; on a tie the port that did not win last time wins.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  // Range check is done on the accepted address so mem_read can be a plain
  // register that is high during ISSUE. 33-bit sum: no wrap near 2^32.
  assign acc_addr = grant1 ? req1_addr : req0_addr;
  assign acc_base = {acc_addr[31:4], 4'b0000};
  assign acc_end  = {1'b0, acc_base} + 33'd15;
  assign acc_oor  = (acc_end >= 33'(ADDR_LIMIT));

  // Ready is gated by reset so every output is 0 while reset is held.
  assign req0_ready = reset & (state_q == IDLE) & grant0;
  assign req1_ready = reset & (state_q == IDLE) & grant1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      port_q        <= 1'b0;
      oor_q         <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      mem_read_q    <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
      resp0_err_q   <= 1'b0;
      resp1_err_q   <= 1'b0;
    end else begin
      mem_read_q    <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant0 | grant1) begin
            port_q       <= grant1;
            addr_q       <= acc_base;
            oor_q        <= acc_oor;
            last_grant_q <= grant1;
            mem_read_q   <= ~acc_oor;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (oor_q) begin
            if (port_q) begin
              resp1_data_q  <= '0;
              resp1_err_q   <= 1'b1;
              resp1_valid_q <= 1'b1;
            end else begin
              resp0_data_q  <= '0;
              resp0_err_q   <= 1'b1;
              resp0_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q   <= 4'(MEM_LATENCY);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Counter hits 0 on this edge: the block is on mem_block_in now.
          if (cnt_q == 4'd1) begin
            if (port_q) begin
              resp1_data_q  <= mem_block_in;
              resp1_err_q   <= 1'b0;
              resp1_valid_q <= 1'b1;
            end else begin
              resp0_data_q  <= mem_block_in;
              resp0_err_q   <= 1'b0;
              resp0_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_address = mem_read_q ? addr_q : 32'd0;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_data  = resp1_data_q;
  assign resp0_err   = resp0_err_q;
  assign resp1_err   = resp1_err_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_refill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_refill_arbiter
//   Self-checking bench for dmem_refill_arbiter. Two instances: the default
//   MEM_LATENCY=1 one carries most scenarios; a MEM_LATENCY=3 one checks the
//   latency parameter. Memories are modelled as 16 blocks of 128 bits behind
//   a MEM_LATENCY-deep register pipeline.
// ---------------------------------------------------------------------------
module tb_dmem_refill_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- DUT (latency 1) ----------------
  logic         req0_valid = 0, req1_valid = 0;
  logic [31:0]  req0_addr = 0, req1_addr = 0;
  logic         req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [127:0] resp0_data, resp1_data, mem_block_in;
  logic         resp0_err, resp1_err, mem_read, busy;
  logic [31:0]  mem_address;
  logic [1:0]   dbg_state;

  dmem_refill_arbiter #(.ADDR_LIMIT(256), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .mem_read(mem_read), .mem_address(mem_address), .mem_block_in(mem_block_in),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT (latency 3) ----------------
  logic         l3_req0_valid = 0, l3_req1_valid = 0;
  logic [31:0]  l3_req0_addr = 0, l3_req1_addr = 0;
  logic         l3_req0_ready, l3_req1_ready, l3_resp0_valid, l3_resp1_valid;
  logic [127:0] l3_resp0_data, l3_resp1_data, l3_mem_block_in;
  logic         l3_resp0_err, l3_resp1_err, l3_mem_read, l3_busy;
  logic [31:0]  l3_mem_address;
  logic [1:0]   l3_dbg_state;

  dmem_refill_arbiter #(.ADDR_LIMIT(256), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(l3_req0_valid), .req0_addr(l3_req0_addr), .req0_ready(l3_req0_ready),
    .resp0_valid(l3_resp0_valid), .resp0_data(l3_resp0_data), .resp0_err(l3_resp0_err),
    .req1_valid(l3_req1_valid), .req1_addr(l3_req1_addr), .req1_ready(l3_req1_ready),
    .resp1_valid(l3_resp1_valid), .resp1_data(l3_resp1_data), .resp1_err(l3_resp1_err),
    .mem_read(l3_mem_read), .mem_address(l3_mem_address), .mem_block_in(l3_mem_block_in),
    .busy(l3_busy), .dbg_state(l3_dbg_state)
  );

  // ---------------- memory models ----------------
  logic [127:0] mem [16];
  logic [127:0] pipe1;
  logic [127:0] pipe3 [3];

  function automatic logic [127:0] blk_pattern(input int b);
    return {32'(4*b+4), 32'(4*b+3), 32'(4*b+2), 32'(4*b+1)};
  endfunction

  always @(posedge clk) begin
    pipe1    <= mem_read ? mem[mem_address[7:4]] : {$urandom(), $urandom(), $urandom(), $urandom()};
    pipe3[0] <= l3_mem_read ? mem[l3_mem_address[7:4]] : {$urandom(), $urandom(), $urandom(), $urandom()};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_block_in    = pipe1;
  assign l3_mem_block_in = pipe3[2];

  // ---------------- monitor (main DUT) ----------------
  int           rd_cyc_q[$];
  logic [31:0]  rd_addr_q[$];
  logic [129:0] resp_q[$];      // {port, err, data}
  int           resp_cyc_q[$];
  int           consec_rd = 0;
  int           dual_resp = 0;
  logic         prev_rd = 0;

  always @(negedge clk) begin
    if (mem_read) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(mem_address);
      if (prev_rd) consec_rd = consec_rd + 1;
    end
    prev_rd = mem_read;
    if (resp0_valid && resp1_valid) dual_resp = dual_resp + 1;
    if (resp0_valid) begin
      resp_q.push_back({1'b0, resp0_err, resp0_data});
      resp_cyc_q.push_back(cyc);
    end
    if (resp1_valid) begin
      resp_q.push_back({1'b1, resp1_err, resp1_data});
      resp_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_cyc_q.delete(); rd_addr_q.delete(); resp_q.delete(); resp_cyc_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0; l3_req0_valid = 0; l3_req1_valid = 0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  // Present a request, wait for ready, return the accept cycle. Leaves the
  // bench at cycle t_acc+1 with the request withdrawn.
  task automatic issue(input int p, input logic [31:0] a, output int t_acc);
    bit got = 0;
    t_acc = -100;
    if (p == 0) begin req0_valid = 1; req0_addr = a; end
    else        begin req1_valid = 1; req1_addr = a; end
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((p == 0) ? req0_ready : req1_ready) begin got = 1; t_acc = cyc; end
      else step();
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout port%0d addr %h: no ready within 20 cycles", p, a);
    end
    step();
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!busy) done = 1; else step();
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy still 1 after 40 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    n_cmp++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, mem_read, busy} !== 8'b0 ||
        resp0_data !== 128'd0 || resp1_data !== 128'd0 || mem_address !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: flags %b data0 %h data1 %h addr %h, want all 0",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, mem_read, busy},
               resp0_data, resp1_data, mem_address);
    end
    n_cmp++;
    if ({l3_busy, l3_mem_read, l3_resp0_valid, l3_resp1_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_l3: %b want 0000", {l3_busy, l3_mem_read, l3_resp0_valid, l3_resp1_valid});
    end
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if ({busy, req0_ready, req1_ready, mem_read} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy/rdy0/rdy1/rd %b want 0000", {busy, req0_ready, req1_ready, mem_read});
    end
  endtask

  task automatic test_single_read();
    int t;
    clear_logs();
    issue(0, 32'h0, t);
    wait_idle();
    n_cmp++;
    if (cyc !== t + 4) begin n_fail++; $display("FAIL single_idle_cycle: %0d want %0d", cyc, t + 4); end
    n_cmp++;
    if (rd_cyc_q.size() !== 1) begin n_fail++; $display("FAIL single_rd_count: %0d want 1", rd_cyc_q.size()); end
    else begin
      n_cmp++;
      if (rd_cyc_q[0] !== t + 1 || rd_addr_q[0] !== 32'h0) begin
        n_fail++; $display("FAIL single_rd: cyc %0d addr %h want cyc %0d addr 0", rd_cyc_q[0], rd_addr_q[0], t + 1);
      end
    end
    n_cmp++;
    if (resp_q.size() !== 1) begin n_fail++; $display("FAIL single_resp_count: %0d want 1", resp_q.size()); end
    else begin
      n_cmp++;
      if (resp_q[0] !== {1'b0, 1'b0, 128'h00000004_00000003_00000002_00000001} || resp_cyc_q[0] !== t + 3) begin
        n_fail++; $display("FAIL single_resp: %h at cyc %0d want port0 blk0 at %0d", resp_q[0], resp_cyc_q[0], t + 3);
      end
    end
  endtask

  task automatic test_unaligned();
    int t;
    clear_logs();
    issue(1, 32'h17, t);
    wait_idle();
    n_cmp++;
    if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== 32'h10) begin
      n_fail++; $display("FAIL unaligned_addr: %0d reads, first %h want one read at 00000010", rd_addr_q.size(),
                         (rd_addr_q.size() > 0) ? rd_addr_q[0] : 32'hx);
    end
    n_cmp++;
    if (resp_q.size() !== 1 || resp_q[0] !== {1'b1, 1'b0, 128'h00000008_00000007_00000006_00000005} ||
        resp_cyc_q[0] !== t + 3) begin
      n_fail++; $display("FAIL unaligned_resp: %0d resps, first %h want port1 blk1 at %0d", resp_q.size(),
                         (resp_q.size() > 0) ? resp_q[0] : 130'hx, t + 3);
    end
    n_cmp++;
    if (resp0_data !== blk_pattern(0) || resp0_err !== 1'b0) begin
      n_fail++; $display("FAIL unaligned_port0_hold: data %h err %b want blk0 err 0", resp0_data, resp0_err);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [4];
    addrs[0] = 32'h100; addrs[1] = 32'hFFFF_FFF0; addrs[2] = 32'hF8; addrs[3] = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      int t;
      longint base;
      bit oor;
      logic [129:0] exp_r;
      base = longint'(addrs[k]) & ~longint'(15);
      oor = (base + 15 >= 256);
      exp_r = {1'b0, oor, oor ? 128'd0 : mem[int'(base) / 16]};
      clear_logs();
      issue(0, addrs[k], t);
      wait_idle();
      n_cmp++;
      if (rd_cyc_q.size() !== (oor ? 0 : 1)) begin
        n_fail++; $display("FAIL range_rd_count addr %h: %0d want %0d", addrs[k], rd_cyc_q.size(), oor ? 0 : 1);
      end
      n_cmp++;
      if (resp_q.size() !== 1 || resp_q[0] !== exp_r || resp_cyc_q[0] !== t + (oor ? 2 : 3)) begin
        n_fail++; $display("FAIL range_resp addr %h: %0d resps, first %h at %0d want %h at %0d", addrs[k],
                           resp_q.size(), (resp_q.size() > 0) ? resp_q[0] : 130'hx,
                           (resp_cyc_q.size() > 0) ? resp_cyc_q[0] : -1, exp_r, t + (oor ? 2 : 3));
      end
    end
    n_cmp++;
    if (resp1_data !== blk_pattern(1) || resp1_err !== 1'b0) begin
      n_fail++; $display("FAIL range_port1_hold: data %h err %b want blk1 err 0", resp1_data, resp1_err);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    clear_logs();
    req0_addr = 32'h0; req1_addr = 32'h10;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 80 && resp_q.size() < 6; i++) step();
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    n_cmp++;
    if (resp_q.size() !== 6) begin n_fail++; $display("FAIL contention_count: %0d resps want 6", resp_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (resp_q[i] !== {1'(i % 2), 1'b0, blk_pattern(i % 2)} ||
            (i > 0 && resp_cyc_q[i] - resp_cyc_q[i-1] !== 4)) begin
          n_fail++; $display("FAIL contention_resp%0d: %h gap %0d want port%0d blk%0d gap 4", i, resp_q[i],
                             (i > 0) ? resp_cyc_q[i] - resp_cyc_q[i-1] : 4, i % 2, i % 2);
        end
      end
    end
    n_cmp++;
    if (dual_resp !== 0) begin n_fail++; $display("FAIL contention_dual: %0d cycles both resp valid want 0", dual_resp); end
  endtask

  task automatic test_latency();
    logic [5:0] obs_busy, obs_resp, obs_rd;
    logic [127:0] data5;
    logic err5;
    obs_busy = '0; obs_resp = '0; obs_rd = '0; data5 = '0; err5 = 1'bx;
    l3_req0_addr = 32'h0; l3_req0_valid = 1;
    #1;
    n_cmp++;
    if (l3_req0_ready !== 1'b1) begin n_fail++; $display("FAIL lat3_ready: %b want 1", l3_req0_ready); end
    for (int k = 1; k <= 6; k++) begin
      step();
      l3_req0_valid = 0;
      obs_busy[k-1] = l3_busy;
      obs_resp[k-1] = l3_resp0_valid;
      obs_rd[k-1]   = l3_mem_read;
      if (k == 5) begin data5 = l3_resp0_data; err5 = l3_resp0_err; end
    end
    n_cmp++;
    if (obs_busy !== 6'b011111) begin n_fail++; $display("FAIL lat3_busy: T+6..T+1 %b want 011111", obs_busy); end
    n_cmp++;
    if (obs_resp !== 6'b010000) begin n_fail++; $display("FAIL lat3_resp: T+6..T+1 %b want 010000", obs_resp); end
    n_cmp++;
    if (obs_rd !== 6'b000001) begin n_fail++; $display("FAIL lat3_rd: T+6..T+1 %b want 000001", obs_rd); end
    n_cmp++;
    if (data5 !== mem[0] || err5 !== 1'b0) begin
      n_fail++; $display("FAIL lat3_data: %h err %b want %h err 0", data5, err5, mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int n_before;
    clear_logs();
    issue(0, 32'h20, t);
    step();                       // now in the wait cycle
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: %b want 1", busy); end
    req0_addr = 32'h0; req1_addr = 32'h10;
    req0_valid = 1; req1_valid = 1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, mem_read, busy} !== 8'b0 ||
        resp0_data !== 128'd0 || resp1_data !== 128'd0 || mem_address !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags %b data0 %h data1 %h addr %h, want all 0",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, mem_read, busy},
               resp0_data, resp1_data, mem_address);
    end
    step(); step();
    n_before = resp_q.size();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_first_grant: rdy0 %b rdy1 %b want 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    n_cmp++;
    if (n_before !== 0 || resp_q.size() !== 1 || resp_q[0] !== {1'b0, 1'b0, mem[0]}) begin
      n_fail++; $display("FAIL midreset_resp: %0d during reset, %0d total, first %h want 0, 1, port0 blk0",
                         n_before, resp_q.size(), (resp_q.size() > 0) ? resp_q[0] : 130'hx);
    end
  endtask

  // Random traffic against a transaction-level model: pending requests per
  // port, round-robin pointer, expected responses in order.
  task automatic test_random();
    logic [129:0] exp_q[$];
    int           exp_cyc_q[$];
    bit           pend [2];
    logic [31:0]  addr [2];
    int           lg;
    int           w;
    for (int b = 0; b < 16; b++) mem[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
    apply_reset();
    clear_logs();
    lg = 1; pend[0] = 0; pend[1] = 0;
    for (int r = 0; r < 60; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1;
          addr[p] = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 287));
        end
      end
      req0_valid = pend[0]; req0_addr = addr[0];
      req1_valid = pend[1]; req1_addr = addr[1];
      if (pend[0] && pend[1]) w = 1 - lg;
      else if (pend[0]) w = 0;
      else if (pend[1]) w = 1;
      else w = -1;
      #1;
      n_cmp++;
      if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin
        n_fail++; $display("FAIL rand_grant round %0d: rdy0 %b rdy1 %b want winner %0d", r, req0_ready, req1_ready, w);
      end
      if (w >= 0) begin
        longint base;
        bit oor;
        base = longint'(addr[w]) & ~longint'(15);
        oor = (base + 15 >= 256);
        exp_q.push_back({1'(w), oor, oor ? 128'd0 : mem[int'(base) / 16]});
        exp_cyc_q.push_back(cyc + (oor ? 2 : 3));
        lg = w;
        pend[w] = 0;
        step();
        if (w == 0) req0_valid = 0; else req1_valid = 0;
        wait_idle();
      end else begin
        step();
      end
    end
    req0_valid = 0; req1_valid = 0;
    step();
    wait_idle();
    n_cmp++;
    if (resp_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: %0d resps want %0d", resp_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (resp_q[i] !== exp_q[i] || resp_cyc_q[i] !== exp_cyc_q[i]) begin
          n_fail++; $display("FAIL rand_resp%0d: %h at %0d want %h at %0d", i, resp_q[i], resp_cyc_q[i],
                             exp_q[i], exp_cyc_q[i]);
        end
      end
    end
    n_cmp++;
    if (consec_rd !== 0) begin n_fail++; $display("FAIL consecutive_mem_read: %0d occurrences want 0", consec_rd); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    for (int b = 0; b < 16; b++) mem[b] = blk_pattern(b);
    test_reset();
    test_single_read();
    test_unaligned();
    test_out_of_range();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
